spi_req_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one `spi_master` among `NUM_REQ` on-chip requesters. Each requester posts a one-byte transfer (slave select plus TX byte). The block grants one requester at a time and drives the master's `start`/`slaveselect`/`data_in`. It then tracks the master's `done` handshake, bounded by a timeout, and returns the received byte with a one-cycle `ack` or `err`. It sits between the register/command logic and `spi_master` in the SPI subsystem.

---
 rtl/spi_req_arbiter_if.sv | 29 ++
 rtl/spi_req_arbiter.sv | 173 +++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_req_arbiter_if.sv
// Bundle of requester-side and spi_master-side signals around spi_req_arbiter.
// The master modport is the arbiter's view; slave is the view of the surrounding logic.
interface spi_req_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] req_ss;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   err;
  logic [7:0]           rx_data;
  logic                 busy;
  logic                 spi_start;
  logic [1:0]           spi_ss;
  logic [7:0]           spi_data;
  logic                 spi_done;
  logic [7:0]           spi_rx;

  modport master (
    input  req, req_ss, req_data, spi_done, spi_rx,
    output grant, ack, err, rx_data, busy, spi_start, spi_ss, spi_data
  );

  modport slave (
    output req, req_ss, req_data, spi_done, spi_rx,
    input  grant, ack, err, rx_data, busy, spi_start, spi_ss, spi_data
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one spi_master among NUM_REQ requesters,
// sequencing start/done with a per-wait-state timeout. All outputs are registered.
module spi_req_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              reset,
  spi_req_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_DONE,
    RESP
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [IDX_W-1:0]   last, last_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic               err_flag, err_flag_nxt;
  logic [NUM_REQ-1:0] grant_nxt, ack_nxt, err_nxt;
  logic [7:0]         rx_nxt, data_nxt;
  logic [1:0]         ss_nxt;
  logic               busy_nxt, start_nxt;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [1:0]         win_ss;
  logic [7:0]         win_data;
  logic               timed_out;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && bus.req[(int'(last) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(last) + k) % NUM_REQ);
      end
    end
  end

  assign win_ss   = bus.req_ss[2*int'(win_idx) +: 2];
  assign win_data = bus.req_data[8*int'(win_idx) +: 8];

  // Saturating counter; the abort fires on the edge where it reaches TIMEOUT.
  assign cnt_inc   = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + 1'b1;
  assign timed_out = (cnt >= CNT_W'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every target gets a default first so no path leaves a value unassigned (no latches).
    state_nxt    = state;
    idx_nxt      = idx;
    last_nxt     = last;
    cnt_nxt      = cnt;
    err_flag_nxt = err_flag;
    grant_nxt    = bus.grant;
    ack_nxt      = '0;
    err_nxt      = '0;
    rx_nxt       = bus.rx_data;
    busy_nxt     = bus.busy;
    start_nxt    = 1'b0;
    ss_nxt       = bus.spi_ss;
    data_nxt     = bus.spi_data;

    unique case (state)
      IDLE: begin
        if (win_found) begin
          idx_nxt            = win_idx;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          ss_nxt             = win_ss;
          data_nxt           = win_data;
          busy_nxt           = 1'b1;
          if (win_ss == 2'b11) begin
            err_flag_nxt = 1'b1;
            state_nxt    = RESP;
          end else begin
            err_flag_nxt = 1'b0;
            start_nxt    = 1'b1;
            state_nxt    = ISSUE;
          end
        end
      end

      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_LOW;
      end

      WAIT_LOW: begin
        if (!bus.spi_done) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_DONE;
        end else begin
          cnt_nxt = cnt_inc;
          if (timed_out) begin
            err_flag_nxt = 1'b1;
            state_nxt    = RESP;
          end
        end
      end

      WAIT_DONE: begin
        if (bus.spi_done) begin
          rx_nxt       = bus.spi_rx;
          err_flag_nxt = 1'b0;
          state_nxt    = RESP;
        end else begin
          cnt_nxt = cnt_inc;
          if (timed_out) begin
            err_flag_nxt = 1'b1;
            state_nxt    = RESP;
          end
        end
      end

      RESP: begin
        if (err_flag) err_nxt = bus.grant;
        else          ack_nxt = bus.grant;
        grant_nxt = '0;
        last_nxt  = idx;
        ss_nxt    = 2'b11;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      last          <= IDX_W'(NUM_REQ - 1);
      cnt           <= '0;
      err_flag      <= 1'b0;
      bus.grant     <= '0;
      bus.ack       <= '0;
      bus.err       <= '0;
      bus.rx_data   <= '0;
      bus.busy      <= 1'b0;
      bus.spi_start <= 1'b0;
      bus.spi_ss    <= 2'b11;
      bus.spi_data  <= '0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      last          <= last_nxt;
      cnt           <= cnt_nxt;
      err_flag      <= err_flag_nxt;
      bus.grant     <= grant_nxt;
      bus.ack       <= ack_nxt;
      bus.err       <= err_nxt;
      bus.rx_data   <= rx_nxt;
      bus.busy      <= busy_nxt;
      bus.spi_start <= start_nxt;
      bus.spi_ss    <= ss_nxt;
      bus.spi_data  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: stimulus pushes expected responses,
// a monitor pops and compares them whenever grant, spi_start, ack or err appear.
module tb_spi_req_arbiter;

  localparam int N  = 3;
  localparam int TO = 15;

  logic clk;
  logic reset;

  spi_req_arbiter_if #(.NUM_REQ(N)) bus ();

  spi_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    bit         is_err;
    logic [7:0] rx;
    int         lat;
    int         starts;
    logic [1:0] ss;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         fall_dly = 1;
  int         rise_dly = 1;
  logic [7:0] good_rx  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected rx_data follows the last successful loopback byte.
  task automatic push(input int idx, input bit is_err, input int lat, input int starts,
                      input logic [1:0] ss, input logic [7:0] d);
    exp_t e;
    e.idx = idx; e.is_err = is_err; e.lat = lat; e.starts = starts; e.ss = ss; e.data = d;
    if (!is_err) good_rx = d;
    e.rx = good_rx;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [1:0] ss, input logic [7:0] d);
    bus.req_ss[2*i +: 2]   = ss;
    bus.req_data[8*i +: 8] = d;
    bus.req[i]             = 1'b1;
  endtask

  // Waits for n ack/err pulses; bits not in keep drop their req on their response.
  task automatic wait_resps(input int n, input logic [N-1:0] keep, input int budget);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if ((|bus.ack) || (|bus.err)) begin
        got++;
        bus.req = bus.req & ~((bus.ack | bus.err) & ~keep);
      end
    end
    check("resp_count", got, n);
  endtask

  task automatic wait_grant(input int i, input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (bus.grant[i]) seen = 1'b1;
    end
    check("grant_seen", seen, 1);
  endtask

  task automatic check_reset_values();
    check("rst_grant", bus.grant, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_err", bus.err, 0);
    check("rst_rx", bus.rx_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_start", bus.spi_start, 0);
    check("rst_ss", bus.spi_ss, 2'b11);
    check("rst_data", bus.spi_data, 0);
  endtask

  // spi_master model: done idles high, falls fall_dly cycles after start,
  // rises rise_dly cycles later with the TX byte looped back.
  initial begin
    logic [7:0] cap;
    bus.spi_done = 1'b1;
    bus.spi_rx   = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.spi_start && !reset) begin
        cap = bus.spi_data;
        repeat (fall_dly) @(negedge clk);
        bus.spi_done = 1'b0;
        repeat (rise_dly) @(negedge clk);
        bus.spi_rx   = cap;
        bus.spi_done = 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    logic [N-1:0] prev_grant = '0;
    int cyc = 0, grant_cyc = 0, starts_seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_grant  = '0;
        starts_seen = 0;
      end else begin
        if (bus.grant != '0 && prev_grant == '0) begin
          grant_cyc   = cyc;
          starts_seen = 0;
          if (sb.size() == 0) check("unexpected_grant", bus.grant, 0);
          else begin
            check("grant_owner", bus.grant, 32'(1) << sb[0].idx);
            check("grant_busy", bus.busy, 1);
            check("grant_ss", bus.spi_ss, sb[0].ss);
            check("grant_data", bus.spi_data, sb[0].data);
          end
        end
        if (bus.spi_start) begin
          starts_seen++;
          if (sb.size() > 0) begin
            check("start_ss", bus.spi_ss, sb[0].ss);
            check("start_data", bus.spi_data, sb[0].data);
          end
        end
        if ((|bus.ack) || (|bus.err)) begin
          if (sb.size() == 0) check("unexpected_resp", {bus.ack, bus.err}, 0);
          else begin
            e = sb.pop_front();
            check("resp_ack", bus.ack, e.is_err ? 0 : (32'(1) << e.idx));
            check("resp_err", bus.err, e.is_err ? (32'(1) << e.idx) : 0);
            check("resp_rx", bus.rx_data, e.rx);
            check("resp_latency", cyc - grant_cyc, e.lat);
            check("resp_starts", starts_seen, e.starts);
            check("resp_grant", bus.grant, 0);
            check("resp_busy", bus.busy, 0);
            check("resp_ss", bus.spi_ss, 2'b11);
          end
        end
        prev_grant = bus.grant;
      end
    end
  end

  // Stimulus
  initial begin
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_ss   = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Fairness: all three held; order 0,1,2,0,1,2 with best-case latency.
    fall_dly = 1; rise_dly = 1;
    set_req(0, 2'd0, 8'h10);
    set_req(1, 2'd1, 8'h21);
    set_req(2, 2'd2, 8'h32);
    for (int r = 0; r < 2; r++) begin
      push(0, 0, 4, 1, 2'd0, 8'h10);
      push(1, 0, 4, 1, 2'd1, 8'h21);
      push(2, 0, 4, 1, 2'd2, 8'h32);
    end
    wait_resps(3, 3'b111, 60);
    wait_resps(3, 3'b000, 60);
    repeat (3) @(negedge clk);

    // Single request with slower master: latency 2 + fall + rise.
    fall_dly = 2; rise_dly = 3;
    push(0, 0, 7, 1, 2'd1, 8'hA5);
    set_req(0, 2'd1, 8'hA5);
    wait_resps(1, 3'b000, 40);
    repeat (3) @(negedge clk);

    // Illegal select on requester 1 (last=0), then 2 and 0 follow.
    fall_dly = 1; rise_dly = 1;
    push(1, 1, 1, 0, 2'd3, 8'h11);
    push(2, 0, 4, 1, 2'd2, 8'h22);
    push(0, 0, 4, 1, 2'd0, 8'h33);
    set_req(1, 2'd3, 8'h11);
    set_req(2, 2'd2, 8'h22);
    set_req(0, 2'd0, 8'h33);
    wait_resps(3, 3'b000, 60);
    repeat (3) @(negedge clk);

    // Reset during WAIT_DONE: no response, requester 0 wins first afterwards.
    fall_dly = 1; rise_dly = 8;
    push(2, 0, 0, 1, 2'd0, 8'h44);
    set_req(2, 2'd0, 8'h44);
    wait_grant(2, 10);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    void'(sb.pop_front());
    good_rx = 8'h00;
    @(negedge clk);
    check_reset_values();
    bus.req = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    fall_dly = 1; rise_dly = 1;
    push(0, 0, 4, 1, 2'd1, 8'h55);
    push(1, 0, 4, 1, 2'd2, 8'h66);
    set_req(0, 2'd1, 8'h55);
    set_req(1, 2'd2, 8'h66);
    wait_resps(2, 3'b000, 40);
    repeat (3) @(negedge clk);

    // Timeout with done stuck high in WAIT_LOW.
    fall_dly = 40; rise_dly = 1;
    push(0, 1, TO + 2, 1, 2'd1, 8'h77);
    set_req(0, 2'd1, 8'h77);
    wait_resps(1, 3'b000, 60);
    repeat (50) @(negedge clk);

    // Timeout with done stuck low in WAIT_DONE.
    fall_dly = 1; rise_dly = 40;
    push(1, 1, TO + 3, 1, 2'd0, 8'h88);
    set_req(1, 2'd0, 8'h88);
    wait_resps(1, 3'b000, 60);
    repeat (50) @(negedge clk);

    // Request dropped during WAIT_DONE still completes with ack.
    fall_dly = 1; rise_dly = 6;
    push(2, 0, 9, 1, 2'd2, 8'h99);
    set_req(2, 2'd2, 8'h99);
    wait_grant(2, 10);
    repeat (4) @(negedge clk);
    bus.req[2] = 1'b0;
    wait_resps(1, 3'b000, 30);
    repeat (3) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
